// File: rtl/conf_pkg.sv
// Shared types for the spike localisation path (spike_accumulator -> spike_locator).
package conf_pkg;

    localparam int unsigned TIME_W     = 32;
    localparam int unsigned X_W        = 11;
    localparam int unsigned Y_W        = 11;
    localparam int unsigned A_W        = 8;
    localparam int unsigned PROD_W     = X_W + A_W;
    localparam int unsigned X_ACC_W    = 28;
    localparam int unsigned A_ACC_W    = 25;
    localparam int unsigned ACC_MAX_CH = 512;

    typedef logic [TIME_W-1:0]  time_t;
    typedef logic [X_W-1:0]     x_t;
    typedef logic [Y_W-1:0]     y_t;
    typedef logic [A_W-1:0]     a_t;
    typedef logic [PROD_W-1:0]  prod_t;
    typedef logic [X_ACC_W-1:0] x_acc_t;
    typedef logic [A_ACC_W-1:0] a_acc_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_FLUSH = 1'b1
    } acc_state_e;

endpackage

// File: rtl/spike_term.sv
// Per-beat weighting term: amplitude thresholding and the coordinate products.
module spike_term
    import conf_pkg::*;
#(
    parameter int unsigned A_MIN = 0
) (
    input  x_t    i_x,
    input  y_t    i_y,
    input  a_t    i_a,
    output prod_t o_wx,
    output prod_t o_wy,
    output a_t    o_w
);

    logic w_pass;

    // A zero threshold passes every amplitude; elaborating it away avoids an always-true compare.
    if (A_MIN == 0) begin : g_no_thr
        assign w_pass = 1'b1;
    end else begin : g_thr
        assign w_pass = (32'(i_a) >= A_MIN);
    end

    assign o_w  = w_pass ? i_a : '0;
    assign o_wx = PROD_W'(i_x) * PROD_W'(o_w);
    assign o_wy = PROD_W'(i_y) * PROD_W'(o_w);

endmodule

// File: rtl/spike_accumulator.sv
// Accumulates amplitude-weighted coordinate sums per event and emits one sum record per event.
module spike_accumulator
    import conf_pkg::*;
#(
    parameter int unsigned A_MIN  = 0,
    parameter int unsigned MAX_CH = ACC_MAX_CH
) (
    input  logic   clk,
    input  logic   rst,
    input  time_t  s_axis_c_time,
    input  x_t     s_axis_c_tx,
    input  y_t     s_axis_c_ty,
    input  a_t     s_axis_c_ta,
    input  logic   s_axis_c_tvalid,
    output logic   s_axis_c_tready,
    input  logic   s_axis_c_tlast,
    input  logic   s_axis_c_tuser,
    output time_t  m_axis_a_time,
    output x_acc_t m_axis_a_tx,
    output x_acc_t m_axis_a_ty,
    output a_acc_t m_axis_a_ta,
    output logic   m_axis_a_tvalid,
    input  logic   m_axis_a_tready,
    output logic   m_axis_a_tlast
);

    if (MAX_CH > ACC_MAX_CH) begin : g_max_ch_check
        $error("spike_accumulator: MAX_CH exceeds the exact-accumulation limit");
    end

    acc_state_e r_state, w_state_nxt;

    x_acc_t r_acc_x, r_acc_y;
    a_acc_t r_acc_a;
    time_t  r_time;
    logic   r_first;
    logic   r_user;
    logic   r_pend_last;

    time_t  r_out_time;
    x_acc_t r_out_x, r_out_y;
    a_acc_t r_out_a;
    logic   r_out_valid, r_out_last;

    prod_t  w_wx, w_wy;
    a_t     w_w;
    x_acc_t w_sum_x, w_sum_y;
    a_acc_t w_sum_a;
    logic   w_beat, w_slot_free, w_tready;
    logic   w_add, w_clear, w_load, w_drop;
    time_t  w_ev_time, w_ld_time;
    x_acc_t w_ld_x, w_ld_y;
    a_acc_t w_ld_a;
    logic   w_ld_user;

    spike_term #(.A_MIN(A_MIN)) u_term (
        .i_x  (s_axis_c_tx),
        .i_y  (s_axis_c_ty),
        .i_a  (s_axis_c_ta),
        .o_wx (w_wx),
        .o_wy (w_wy),
        .o_w  (w_w)
    );

    assign s_axis_c_tready = w_tready & ~rst;
    assign w_beat          = s_axis_c_tvalid & s_axis_c_tready;
    assign w_slot_free     = ~r_out_valid | m_axis_a_tready;

    assign w_sum_x = r_acc_x + {{(X_ACC_W-PROD_W){1'b0}}, w_wx};
    assign w_sum_y = r_acc_y + {{(X_ACC_W-PROD_W){1'b0}}, w_wy};
    assign w_sum_a = r_acc_a + {{(A_ACC_W-A_W){1'b0}}, w_w};

    // A single-beat event has its timestamp only on the bus, not yet in r_time.
    assign w_ev_time = r_first ? s_axis_c_time : r_time;

    // FLUSH drains the stored event; ACCUM loads the event closing on this beat.
    assign w_ld_time = (r_state == ST_FLUSH) ? r_time  : w_ev_time;
    assign w_ld_x    = (r_state == ST_FLUSH) ? r_acc_x : w_sum_x;
    assign w_ld_y    = (r_state == ST_FLUSH) ? r_acc_y : w_sum_y;
    assign w_ld_a    = (r_state == ST_FLUSH) ? r_acc_a : w_sum_a;
    assign w_ld_user = (r_state == ST_FLUSH) ? r_user  : s_axis_c_tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tready    = 1'b0;
        w_add       = 1'b0;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            ST_ACCUM: begin
                w_tready = 1'b1;
                if (s_axis_c_tvalid && !rst) begin
                    if (!s_axis_c_tlast) begin
                        w_add = 1'b1;
                    end else if (w_slot_free) begin
                        w_clear = 1'b1;
                        w_load  = (w_sum_a != '0);
                        w_drop  = (w_sum_a == '0);
                    end else begin
                        w_add       = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_slot_free) begin
                    w_clear     = 1'b1;
                    w_load      = (r_acc_a != '0);
                    w_drop      = (r_acc_a == '0);
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_x     <= '0;
            r_acc_y     <= '0;
            r_acc_a     <= '0;
            r_time      <= '0;
            r_first     <= 1'b1;
            r_user      <= 1'b0;
            r_pend_last <= 1'b0;
            r_out_time  <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_a     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_clear) begin
                r_acc_x <= '0;
                r_acc_y <= '0;
                r_acc_a <= '0;
            end else if (w_add) begin
                r_acc_x <= w_sum_x;
                r_acc_y <= w_sum_y;
                r_acc_a <= w_sum_a;
            end
            if (w_beat) begin
                r_first <= s_axis_c_tlast;
                if (r_first) begin
                    r_time <= s_axis_c_time;
                end
                if (s_axis_c_tlast) begin
                    r_user <= s_axis_c_tuser;
                end
            end
            if (w_load) begin
                r_out_time  <= w_ld_time;
                r_out_x     <= w_ld_x;
                r_out_y     <= w_ld_y;
                r_out_a     <= w_ld_a;
                r_out_last  <= w_ld_user | r_pend_last;
                r_out_valid <= 1'b1;
                r_pend_last <= 1'b0;
            end else begin
                if (m_axis_a_tready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_drop && w_ld_user) begin
                    r_pend_last <= 1'b1;
                end
            end
        end
    end

    assign m_axis_a_time   = r_out_time;
    assign m_axis_a_tx     = r_out_x;
    assign m_axis_a_ty     = r_out_y;
    assign m_axis_a_ta     = r_out_a;
    assign m_axis_a_tvalid = r_out_valid;
    assign m_axis_a_tlast  = r_out_last;

endmodule

// File: tb/tb_spike_accumulator.sv
// Self-checking bench for spike_accumulator: scoreboard of expected sum records plus directed corner cases.
module tb_spike_accumulator;
    import conf_pkg::*;

    typedef struct {
        time_t  t;
        x_acc_t tx;
        x_acc_t ty;
        a_acc_t ta;
        logic   last;
    } rec_t;

    typedef struct {
        x_t    x;
        y_t    y;
        a_t    a;
        time_t t;
        logic  user;
        rec_t  exp;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    time_t  s_time = '0;
    x_t     s_tx = '0;
    y_t     s_ty = '0;
    a_t     s_ta = '0;
    logic   s_last = 1'b0;
    logic   s_user = 1'b0;
    logic   s_valid1 = 1'b0, s_valid2 = 1'b0;
    logic   s_ready1, s_ready2;
    logic   m_ready1 = 1'b1, m_ready2 = 1'b1;
    time_t  m_time1, m_time2;
    x_acc_t m_tx1, m_ty1, m_tx2, m_ty2;
    a_acc_t m_ta1, m_ta2;
    logic   m_valid1, m_valid2, m_last1, m_last2;

    rec_t q1[$];
    rec_t q2[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    spike_accumulator u_dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_c_time   (s_time),
        .s_axis_c_tx     (s_tx),
        .s_axis_c_ty     (s_ty),
        .s_axis_c_ta     (s_ta),
        .s_axis_c_tvalid (s_valid1),
        .s_axis_c_tready (s_ready1),
        .s_axis_c_tlast  (s_last),
        .s_axis_c_tuser  (s_user),
        .m_axis_a_time   (m_time1),
        .m_axis_a_tx     (m_tx1),
        .m_axis_a_ty     (m_ty1),
        .m_axis_a_ta     (m_ta1),
        .m_axis_a_tvalid (m_valid1),
        .m_axis_a_tready (m_ready1),
        .m_axis_a_tlast  (m_last1)
    );

    spike_accumulator #(.A_MIN(4)) u_dut_thr (
        .clk             (clk),
        .rst             (rst),
        .s_axis_c_time   (s_time),
        .s_axis_c_tx     (s_tx),
        .s_axis_c_ty     (s_ty),
        .s_axis_c_ta     (s_ta),
        .s_axis_c_tvalid (s_valid2),
        .s_axis_c_tready (s_ready2),
        .s_axis_c_tlast  (s_last),
        .s_axis_c_tuser  (s_user),
        .m_axis_a_time   (m_time2),
        .m_axis_a_tx     (m_tx2),
        .m_axis_a_ty     (m_ty2),
        .m_axis_a_ta     (m_ta2),
        .m_axis_a_tvalid (m_valid2),
        .m_axis_a_tready (m_ready2),
        .m_axis_a_tlast  (m_last2)
    );

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endfunction

    function automatic void chk_rec(input string name, input time_t t, input x_acc_t tx,
                                    input x_acc_t ty, input a_acc_t ta, input logic last,
                                    input rec_t e);
        chk({name, "_time"}, t, e.t);
        chk({name, "_tx"}, 32'(tx), 32'(e.tx));
        chk({name, "_ty"}, 32'(ty), 32'(e.ty));
        chk({name, "_ta"}, 32'(ta), 32'(e.ta));
        chk({name, "_tlast"}, 32'(last), 32'(e.last));
    endfunction

    // Output monitors: every completed output handshake must match the head of its queue.
    always @(negedge clk) begin : mon1
        rec_t e;
        if (!rst && m_valid1 && m_ready1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL dut_extra_record: got tx=%0d ty=%0d ta=%0d, required no record", m_tx1, m_ty1, m_ta1);
            end else begin
                e = q1.pop_front();
                chk_rec("dut_rec", m_time1, m_tx1, m_ty1, m_ta1, m_last1, e);
            end
        end
    end

    always @(negedge clk) begin : mon2
        rec_t e;
        if (!rst && m_valid2 && m_ready2) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL thr_extra_record: got tx=%0d ty=%0d ta=%0d, required no record", m_tx2, m_ty2, m_ta2);
            end else begin
                e = q2.pop_front();
                chk_rec("thr_rec", m_time2, m_tx2, m_ty2, m_ta2, m_last2, e);
            end
        end
    end

    task automatic send(input int sel, input x_t x, input y_t y, input a_t a, input time_t t,
                        input logic last, input logic user);
        logic ok;
        int unsigned n;
        s_tx = x; s_ty = y; s_ta = a; s_time = t; s_last = last; s_user = user;
        if (sel == 1) s_valid1 = 1'b1;
        else          s_valid2 = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = (sel == 1) ? s_ready1 : s_ready2;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid1 = 1'b0;
        s_valid2 = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: got no tready in %0d cycles, required acceptance", n);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[8];
        tbl[0] = '{x: 1,    y: 2,    a: 3,   t: 32'h10, user: 0, exp: '{32'h10, 3,      6,      3,   0}};
        tbl[1] = '{x: 100,  y: 200,  a: 50,  t: 32'h11, user: 0, exp: '{32'h11, 5000,   10000,  50,  0}};
        tbl[2] = '{x: 2047, y: 2047, a: 255, t: 32'h12, user: 0, exp: '{32'h12, 521985, 521985, 255, 0}};
        tbl[3] = '{x: 0,    y: 5,    a: 7,   t: 32'h13, user: 0, exp: '{32'h13, 0,      35,     7,   0}};
        tbl[4] = '{x: 9,    y: 0,    a: 1,   t: 32'h14, user: 0, exp: '{32'h14, 9,      0,      1,   0}};
        tbl[5] = '{x: 12,   y: 34,   a: 56,  t: 32'h15, user: 0, exp: '{32'h15, 672,    1904,   56,  0}};
        tbl[6] = '{x: 500,  y: 600,  a: 4,   t: 32'h16, user: 0, exp: '{32'h16, 2000,   2400,   4,   0}};
        tbl[7] = '{x: 33,   y: 44,   a: 2,   t: 32'h17, user: 1, exp: '{32'h17, 66,     88,     2,   1}};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 32'(s_ready1), 0);
        chk("rst_tvalid", 32'(m_valid1), 0);
        chk("rst_tlast", 32'(m_last1), 0);
        chk("rst_tx", 32'(m_tx1), 0);
        chk("rst_ty", 32'(m_ty1), 0);
        chk("rst_ta", 32'(m_ta1), 0);
        chk("rst_time", m_time1, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic three-beat sum with one-cycle output latency
        q1.push_back('{32'h100, 240, 340, 10, 1});
        send(1, 10, 20, 5, 32'h100, 0, 0);
        send(1, 30, 40, 3, 32'h999, 0, 0);
        send(1, 50, 60, 2, 32'h999, 1, 1);
        @(negedge clk);
        chk("basic_latency_valid", 32'(m_valid1), 1);
        @(posedge clk); #1;

        // Streaming single-beat events: one record per cycle, no gaps
        for (int i = 0; i < 8; i++) begin
            q1.push_back(tbl[i].exp);
            s_tx = tbl[i].x; s_ty = tbl[i].y; s_ta = tbl[i].a; s_time = tbl[i].t;
            s_last = 1'b1; s_user = tbl[i].user; s_valid1 = 1'b1;
            @(negedge clk);
            chk("stream_tready", 32'(s_ready1), 1);
            if (i > 0) chk("stream_gap", 32'(m_valid1), 1);
            @(posedge clk); #1;
        end
        s_valid1 = 1'b0;
        @(negedge clk);
        chk("stream_gap", 32'(m_valid1), 1);
        repeat (2) @(posedge clk); #1;

        // Backpressure: event 2 closes while event 1 is held, forcing FLUSH
        m_ready1 = 1'b0;
        q1.push_back('{32'h200, 5, 5, 3, 0});
        q1.push_back('{32'h300, 63, 76, 13, 1});
        send(1, 1, 1, 1, 32'h200, 0, 1);
        send(1, 2, 2, 2, 32'h999, 1, 0);
        send(1, 3, 4, 5, 32'h300, 0, 0);
        send(1, 6, 7, 8, 32'h999, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_tready", 32'(s_ready1), 0);
            chk("hold_valid", 32'(m_valid1), 1);
            chk("hold_tx", 32'(m_tx1), 5);
            @(posedge clk); #1;
        end
        m_ready1 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_no_bubble", 32'(m_valid1), 1);
        repeat (3) @(posedge clk); #1;

        // Zero-weight event is dropped; its batch-end flag moves to the next record
        send(1, 5, 5, 0, 32'h400, 1, 1);
        @(negedge clk);
        chk("zero_w_no_valid", 32'(m_valid1), 0);
        @(posedge clk); #1;
        q1.push_back('{32'h401, 7, 9, 1, 1});
        send(1, 7, 9, 1, 32'h401, 1, 0);
        repeat (3) @(posedge clk); #1;

        // Mid-event reset discards the partial event
        send(1, 4, 4, 4, 32'h500, 0, 0);
        send(1, 5, 5, 5, 32'h999, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tready", 32'(s_ready1), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q1.push_back('{32'h501, 1, 1, 1, 0});
        send(1, 1, 1, 1, 32'h501, 1, 0);
        repeat (3) @(posedge clk); #1;

        // Threshold instance (A_MIN = 4)
        q2.push_back('{32'h100, 50, 100, 5, 1});
        send(2, 10, 20, 5, 32'h100, 0, 0);
        send(2, 30, 40, 3, 32'h999, 0, 0);
        send(2, 50, 60, 2, 32'h999, 1, 1);
        q2.push_back('{32'h600, 12, 12, 4, 0});
        send(2, 3, 3, 4, 32'h600, 1, 0);
        send(2, 9, 9, 3, 32'h601, 1, 1);
        q2.push_back('{32'h602, 8, 8, 4, 1});
        send(2, 2, 2, 4, 32'h602, 1, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("dut_queue_empty", q1.size(), 0);
        chk("thr_queue_empty", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
